// File: rtl/treasure_result_tx_if.sv
// -----------------------------------------------------------------------------
// treasure_result_tx_if
// Two-wire clocked serial link between the FPGA treasure-result transmitter
// and the Arduino, plus the Arduino's request line and the transmitter's
// busy indication.
//
// Signals:
//   REQ       Arduino -> FPGA  request; asynchronous level, rising edge asks
//                              for one message
//   SER_CLK   FPGA -> Arduino  serial clock; Arduino samples on rising edge
//   SER_DATA  FPGA -> Arduino  serial data
//   BUSY      FPGA -> Arduino  high while a message or post-message gap runs
//
// Modports:
//   master  transmitter side (FPGA)
//   slave   receiver side (Arduino / testbench)
// -----------------------------------------------------------------------------
interface treasure_result_tx_if;
  logic REQ;
  logic SER_CLK;
  logic SER_DATA;
  logic BUSY;

  modport master (
    input  REQ,
    output SER_CLK,
    output SER_DATA,
    output BUSY
  );

  modport slave (
    output REQ,
    input  SER_CLK,
    input  SER_DATA,
    input  BUSY
  );
endinterface : treasure_result_tx_if

// File: rtl/treasure_result_tx.sv
// -----------------------------------------------------------------------------
// treasure_result_tx
// Transmit end of the per-frame treasure classification. RESULT/SHAPE are
// sampled once per frame (one cycle after the VGA_VSYNC_NEG falling edge),
// debounced over STABLE_FRAMES identical frames into CODE, and shifted to the
// Arduino over SER_CLK/SER_DATA whenever the Arduino raises REQ.
//
// Message (MSB first): start bit 1, CODE[3:0], parity (odd over code + parity).
// Optional build macro TX_FRAME_TAG_EN inserts a 3-bit rolling message tag
// between CODE[0] and the parity bit (parity then also covers the tag).
//
// Parameters:
//   STABLE_FRAMES  identical frame samples needed before CODE updates (1..15)
//   BIT_CYCLES     CLK cycles per SER_CLK half-period and gap length (>=2)
//
// Ports:
//   CLK            system clock
//   RESET          synchronous, active-high reset
//   VGA_VSYNC_NEG  frame sync; falling edge marks a frame boundary
//   RESULT[1:0]    colour code (00 none, 01 red, 10 blue)
//   SHAPE[1:0]     shape code (11 triangle, 10 square, 01 diamond, 00 none)
//   CODE_VALID     a stable code has been captured since reset
//   CODE[3:0]      last stable code {RESULT, SHAPE}
//   ser            serial link interface (master side: REQ in,
//                  SER_CLK/SER_DATA/BUSY out)
// -----------------------------------------------------------------------------
module treasure_result_tx #(
  parameter int STABLE_FRAMES = 3,
  parameter int BIT_CYCLES    = 25
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        VGA_VSYNC_NEG,
  input  logic [1:0]                  RESULT,
  input  logic [1:0]                  SHAPE,
  output logic                        CODE_VALID,
  output logic [3:0]                  CODE,
  treasure_result_tx_if.master        ser
);

`ifdef TX_FRAME_TAG_EN
  localparam int MSG_LEN = 9;
`else
  localparam int MSG_LEN = 6;
`endif

  localparam int              CNT_W      = $clog2(BIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [3:0]      STABLE_MAX = 4'(STABLE_FRAMES);
  localparam logic [3:0]      LAST_BIT   = 4'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  // ---------------------------------------------------------------------------
  // Frame sampling and debounce
  // ---------------------------------------------------------------------------
  logic       vsync_q, vsync_d;
  logic       sample_pending_q, sample_pending_d;
  logic [3:0] prev_cand_q, prev_cand_d;
  logic [3:0] stable_cnt_q, stable_cnt_d;
  logic [3:0] code_q, code_d;
  logic       code_valid_q, code_valid_d;
  logic [3:0] cand;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    vsync_d          = VGA_VSYNC_NEG;
    // The image processor updates RESULT/SHAPE on the falling edge itself, so
    // the sample is deferred by one cycle.
    sample_pending_d = vsync_q & ~VGA_VSYNC_NEG;
    cand             = (RESULT == 2'b00) ? 4'b0000 : {RESULT, SHAPE};
    prev_cand_d      = prev_cand_q;
    stable_cnt_d     = stable_cnt_q;
    code_d           = code_q;
    code_valid_d     = code_valid_q;

    if (sample_pending_q) begin
      if (cand == prev_cand_q) begin
        if (stable_cnt_q < STABLE_MAX) begin
          stable_cnt_d = stable_cnt_q + 4'd1;
        end
      end else begin
        prev_cand_d  = cand;
        stable_cnt_d = 4'd1;
      end
      // Decision uses the updated count so CODE lands in the cycle after
      // the sample, two cycles after the VSYNC edge.
      if (stable_cnt_d >= STABLE_MAX) begin
        code_d       = cand;
        code_valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vsync_q          <= 1'b0;
      sample_pending_q <= 1'b0;
      prev_cand_q      <= 4'b0000;
      stable_cnt_q     <= 4'd0;
      code_q           <= 4'b0000;
      code_valid_q     <= 1'b0;
    end else begin
      vsync_q          <= vsync_d;
      sample_pending_q <= sample_pending_d;
      prev_cand_q      <= prev_cand_d;
      stable_cnt_q     <= stable_cnt_d;
      code_q           <= code_d;
      code_valid_q     <= code_valid_d;
    end
  end

  assign CODE       = code_q;
  assign CODE_VALID = code_valid_q;

  // ---------------------------------------------------------------------------
  // REQ synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic req_s1_q, req_s2_q, req_dly_q;
  logic req_rise;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_s1_q  <= 1'b0;
      req_s2_q  <= 1'b0;
      req_dly_q <= 1'b0;
    end else begin
      req_s1_q  <= ser.REQ;
      req_s2_q  <= req_s1_q;
      req_dly_q <= req_s2_q;
    end
  end

  assign req_rise = req_s2_q & ~req_dly_q;

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;      // 0: SER_CLK low half, 1: high half
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [MSG_LEN-1:0] msg_q, msg_d;          // MSB is the bit on the wire
  logic [MSG_LEN-1:0] msg_new;
  logic [3:0]         snap;
  logic               ser_clk_q, ser_clk_d;
  logic               ser_data_q, ser_data_d;
  logic               busy_q, busy_d;

  assign snap = code_valid_q ? code_q : 4'b0000;

`ifdef TX_FRAME_TAG_EN
  logic [2:0] tag_q, tag_d;
  assign msg_new = {1'b1, snap, tag_q, ~^{snap, tag_q}};
`else
  assign msg_new = {1'b1, snap, ~^snap};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    msg_d     = msg_q;
`ifdef TX_FRAME_TAG_EN
    tag_d     = tag_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Edges arriving while busy are simply not looked at here: dropped.
        if (req_rise) begin
          state_d   = S_SHIFT;
          cnt_d     = CNT_RELOAD;
          phase_d   = 1'b0;
          bit_idx_d = 4'd0;
          msg_d     = msg_new;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = CNT_RELOAD;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_idx_q == LAST_BIT) begin
            state_d = S_GAP;
          end else begin
            phase_d   = 1'b0;
            bit_idx_d = bit_idx_q + 4'd1;
            msg_d     = {msg_q[MSG_LEN-2:0], 1'b0};
          end
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
`ifdef TX_FRAME_TAG_EN
          tag_d   = tag_q + 3'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so the pins change exactly
    // on the phase boundaries and never glitch.
    ser_clk_d  = (state_d == S_SHIFT) && phase_d;
    ser_data_d = (state_d == S_SHIFT) ? msg_d[MSG_LEN-1] : 1'b0;
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      bit_idx_q  <= 4'd0;
      msg_q      <= '0;
      ser_clk_q  <= 1'b0;
      ser_data_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TX_FRAME_TAG_EN
      tag_q      <= 3'b000;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      msg_q      <= msg_d;
      ser_clk_q  <= ser_clk_d;
      ser_data_q <= ser_data_d;
      busy_q     <= busy_d;
`ifdef TX_FRAME_TAG_EN
      tag_q      <= tag_d;
`endif
    end
  end

  assign ser.SER_CLK  = ser_clk_q;
  assign ser.SER_DATA = ser_data_q;
  assign ser.BUSY     = busy_q;

endmodule : treasure_result_tx
